// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the bit-serial magnitude comparator:
//   - FSM state type and state encodings (IDLE, RUN, DONE)
//   - compare-mode constants for the SIGNED parameter
//   - helper function that sizes the bit-index counter
// No ports (package).
// -----------------------------------------------------------------------------
package cmp_pkg;

    // FSM state type and its encodings.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Compare modes selected through the SIGNED parameter.
    localparam int CMP_UNSIGNED = 0;
    localparam int CMP_SIGNED   = 1;

    // Width of the bit-index counter. A 1-bit operand still needs a 1-bit
    // index, so the result is never allowed to drop to zero.
    function automatic int idx_width(input int width);
        if (width <= 1) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage : cmp_pkg

// File: rtl/cmp_bit_cell.sv
// -----------------------------------------------------------------------------
// cmp_bit_cell
// Purely combinational 1-bit magnitude compare cell.
// Ports:
//   x   in   bit of operand A
//   y   in   bit of operand B
//   inv in   swap the greater/less sense (used for a two's-complement sign bit)
//   e   out  x == y
//   g   out  x > y  (x < y when inv=1)
//   l   out  x < y  (x > y when inv=1)
// -----------------------------------------------------------------------------
module cmp_bit_cell (
    input  logic x,
    input  logic y,
    input  logic inv,
    output logic e,
    output logic g,
    output logic l
);

    logic g_raw_s;
    logic l_raw_s;

    // Plain unsigned 1-bit compare, then optional swap of the g/l sense.
    always_comb begin
        e       = ~(x ^ y);
        g_raw_s = x & ~y;
        l_raw_s = ~x & y;
        if (inv) begin
            g = l_raw_s;
            l = g_raw_s;
        end else begin
            g = g_raw_s;
            l = l_raw_s;
        end
    end

endmodule : cmp_bit_cell

// File: rtl/serial_mag_comparator.sv
// -----------------------------------------------------------------------------
// serial_mag_comparator
// Bit-serial magnitude comparator. Operands are captured on an accepted start,
// then scanned MSB-first one bit per clock through a single cmp_bit_cell; the
// scan stops at the first differing bit.
// Parameters:
//   WIDTH   operand width, 1..64
//   SIGNED  0 = unsigned compare, 1 = two's-complement compare
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   compare request, honoured only while busy=0
//   a, b   in   operands, captured on the accepted start edge
//   busy   out  compare in progress
//   done   out  one-cycle pulse when Eq/gt/lt become valid
//   Eq     out  a == b   (held until the next accepted start)
//   gt     out  a >  b   (same validity as Eq)
//   lt     out  a <  b   (same validity as Eq)
// -----------------------------------------------------------------------------
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = CMP_UNSIGNED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             Eq,
    output logic             gt,
    output logic             lt
);

    localparam int            IW       = idx_width(WIDTH);
    localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic             cell_x_s;
    logic             cell_y_s;
    logic             cell_inv_s;
    logic             cell_e_s;
    logic             cell_g_s;
    logic             cell_l_s;

    // Select the bit under test; the sign bit of a signed compare has its
    // greater/less sense inverted (a 1 there means the smaller value).
    always_comb begin
        cell_x_s   = a_q[idx_q];
        cell_y_s   = b_q[idx_q];
        if ((SIGNED == CMP_SIGNED) && (idx_q == IDX_MSB)) begin
            cell_inv_s = 1'b1;
        end else begin
            cell_inv_s = 1'b0;
        end
    end

    cmp_bit_cell u_cell (
        .x   (cell_x_s),
        .y   (cell_y_s),
        .inv (cell_inv_s),
        .e   (cell_e_s),
        .g   (cell_g_s),
        .l   (cell_l_s)
    );

    // Next-state logic for FSM, operand registers, index and results.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_MSB;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // A differing bit decides the result; the index-zero exit is
                // checked before decrementing so idx never wraps.
                if (!cell_e_s) begin
                    state_d = ST_DONE;
                    gt_d    = cell_g_s;
                    lt_d    = cell_l_s;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (idx_q == IDX_ZERO) begin
                    state_d = ST_DONE;
                    eq_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q - IDX_ONE;
                end
            end

            ST_DONE: begin
                // Back-to-back compares go straight from DONE to RUN.
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_MSB;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                eq_d    = 1'b0;
                gt_d    = 1'b0;
                lt_d    = 1'b0;
                idx_d   = IDX_ZERO;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IDX_ZERO;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule : serial_mag_comparator

// File: tb/tb_serial_mag_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_comparator
// Directed plus randomized bench for serial_mag_comparator. Three instances
// share clk/rst/start/a/b: 8-bit unsigned, 8-bit signed and 1-bit signed.
// Expected results and latencies come from a reference model that compares
// the operands as integers and locates the highest differing bit.
// -----------------------------------------------------------------------------
module tb_serial_mag_comparator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;

    logic busy_u8, done_u8, eq_u8, gt_u8, lt_u8;
    logic busy_s8, done_s8, eq_s8, gt_s8, lt_s8;
    logic busy_s1, done_s1, eq_s1, gt_s1, lt_s1;

    int checks;
    int errors;

    serial_mag_comparator #(.WIDTH(8), .SIGNED(0)) dut_u8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy_u8), .done(done_u8), .Eq(eq_u8), .gt(gt_u8), .lt(lt_u8)
    );

    serial_mag_comparator #(.WIDTH(8), .SIGNED(1)) dut_s8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy_s8), .done(done_s8), .Eq(eq_s8), .gt(gt_s8), .lt(lt_s8)
    );

    serial_mag_comparator #(.WIDTH(1), .SIGNED(1)) dut_s1 (
        .clk(clk), .rst(rst), .start(start), .a(a[0:0]), .b(b[0:0]),
        .busy(busy_s1), .done(done_s1), .Eq(eq_s1), .gt(gt_s1), .lt(lt_s1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, done, Eq, gt, lt} of the selected instance: 0=u8, 1=s8, 2=s1.
    function automatic logic [4:0] obs(input int sel);
        case (sel)
            0:       return {busy_u8, done_u8, eq_u8, gt_u8, lt_u8};
            1:       return {busy_s8, done_s8, eq_s8, gt_s8, lt_s8};
            default: return {busy_s1, done_s1, eq_s1, gt_s1, lt_s1};
        endcase
    endfunction

    function automatic int width_of(input int sel);
        return (sel == 2) ? 1 : 8;
    endfunction

    function automatic bit signed_of(input int sel);
        return (sel != 0);
    endfunction

    // Reference: integer compare plus position of highest differing bit.
    task automatic ref_model(input logic [7:0] av, input logic [7:0] bv,
                             input int w, input bit sgn,
                             output logic [2:0] res, output int edges);
        longint ai, bi;
        longint m;
        logic [7:0] diff;
        int p;
        m  = (64'sd1 <<< w) - 64'sd1;
        ai = longint'(av) & m;
        bi = longint'(bv) & m;
        if (sgn && ai >= (64'sd1 <<< (w - 1))) ai = ai - (64'sd1 <<< w);
        if (sgn && bi >= (64'sd1 <<< (w - 1))) bi = bi - (64'sd1 <<< w);
        res  = {ai == bi, ai > bi, ai < bi};
        diff = (av ^ bv) & 8'(m);
        p = -1;
        for (int i = 0; i < w; i++) begin
            if (diff[i]) p = i;
        end
        if (p < 0) edges = w + 1;
        else       edges = (w - 1 - p) + 2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Wait until done on instance sel, checking busy meanwhile; n counts edges
    // since the accepting start edge (which is edge 1).
    task automatic wait_done(input int sel, input string tag, inout int n);
        logic [4:0] o;
        while (n < 100) begin
            o = obs(sel);
            if (o[3] === 1'b1) break;
            chk({tag, "_busy"}, o, 5'b10000);
            tick();
            n++;
        end
    endtask

    // One full compare on instance sel, with operand scrambling after accept
    // and a result-hold check afterwards.
    task automatic do_cmp(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          input string tag);
        logic [2:0] res;
        int exp_edges;
        int n;
        ref_model(av, bv, width_of(sel), signed_of(sel), res, exp_edges);
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        chk({tag, "_accept"}, obs(sel), 5'b10000);
        n = 1;
        wait_done(sel, tag, n);
        chk_int({tag, "_latency"}, n, exp_edges);
        chk({tag, "_result"}, obs(sel), {2'b01, res});
        tick();
        chk({tag, "_hold1"}, obs(sel), {2'b00, res});
        tick();
        chk({tag, "_hold2"}, obs(sel), {2'b00, res});
    endtask

    initial begin
        logic [2:0] res;
        int exp_edges;
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_u8", obs(0), 5'b00000);
        chk("reset_s8", obs(1), 5'b00000);
        chk("reset_s1", obs(2), 5'b00000);

        // Directed compares.
        do_cmp(0, 8'hA5, 8'hA5, "eq_a5");
        do_cmp(0, 8'h80, 8'h7F, "msb_u8");
        do_cmp(1, 8'h80, 8'h7F, "msb_s8");
        do_cmp(0, 8'h12, 8'h13, "lsb_u8");

        // Start while busy is ignored; start in DONE chains directly.
        ref_model(8'h40, 8'h00, 8, 1'b0, res, exp_edges);
        a = 8'h40; b = 8'h00; start = 1'b1;
        tick();
        a = 8'h00; b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignore_busy", obs(0), 5'b10000);
        tick();
        chk_int("ignore_latency", 3, exp_edges);
        chk("ignore_result", obs(0), {2'b01, res});
        a = 8'h01; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        chk("chain_accept", obs(0), 5'b10000);
        n = 1;
        wait_done(0, "chain", n);
        chk_int("chain_latency", n, 9);
        chk("chain_result", obs(0), 5'b01100);
        tick();

        // Reset in the middle of a compare.
        a = 8'h00; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_u8", obs(0), 5'b00000);
        tick();
        chk("midrst_idle", obs(0), 5'b00000);
        do_cmp(0, 8'h03, 8'h02, "after_rst");

        // Reset and start together: reset wins.
        a = 8'h55; b = 8'hAA; start = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_start", obs(0), 5'b00000);
        tick();
        chk("rst_start_idle", obs(0), 5'b00000);

        // Randomized compares on both 8-bit instances.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = (i % 4 == 0) ? ra : ((i % 4 == 1) ? (ra ^ (8'h01 << (i % 8))) : 8'($urandom));
            do_cmp(i % 2, ra, rb, "rand");
        end

        // 1-bit signed: the single bit is the sign bit.
        do_cmp(2, 8'h01, 8'h00, "w1_signed");
        // Let the 8-bit instances finish before ending.
        for (int i = 0; i < 10; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_mag_comparator
